set_assoc_cache_ctrl: RTL and testbench
=======================================

// Module: set_assoc_cache_ctrl
// PURPOSE
//  Parametrised, synthesisable set-associative cache tag/replacement controller with a valid/ready request/response handshake.
//  Holds tag, valid and dirty state per way, with true-LRU age counters per set, write-back dirty tracking, flush, and saturating hit/miss counters.
//  Sits between the trace/CPU request source and the data array / next-level memory; the eviction fields drive write-back.
// PARAMETERS
//  ADDR_W    24  request address width
//  OFFSET_W  3   block-offset bits
//  SET_W     3   set-index bits; SETS = 2**SET_W
//  WAYS      4   associativity, >=2, power of two
//  WAY_W     2   clog2(WAYS); TAG_W = ADDR_W-SET_W-OFFSET_W
// PORTS
//  clk               in   1        single clock, rising edge
//  rst               in   1        synchronous reset, active-high
//  flush             in   1        invalidate all lines; sampled only in IDLE
//  req_valid         in   1        request present
//  req_ready         out  1        controller can accept a request
//  req_write         in   1        1=write, 0=read
//  req_addr          in   ADDR_W   byte address; set=[OFFSET_W+:SET_W], tag=[ADDR_W-1-:TAG_W]
//  resp_valid        out  1        response present; held until resp_ready
//  resp_ready        in   1        consumer takes response
//  resp_hit          out  1        1=hit, 0=miss
//  resp_way          out  WAY_W    way hit or way filled
//  resp_evict_valid  out  1        miss replaced a valid line
//  resp_evict_dirty  out  1        replaced line was dirty (write-back needed)
//  resp_evict_tag    out  TAG_W    tag of the replaced line
//  hit_count         out  32       saturating hit total
//  miss_count        out  32       saturating miss total
// BEHAVIOUR
//  - Reset: rst=1 at an edge, from any state, forces INIT; all outputs 0 on the next cycle, counters 0; any in-flight request is dropped.
//  - FSM: INIT -> IDLE -> LOOKUP -> RESP -> IDLE.
//  - INIT: sweeps sets 0..SETS-1, one per cycle, clearing valid/dirty; ages of way j set to j.
//    req_ready=0 throughout; IDLE is entered after SETS cycles.
//  - IDLE: req_ready=1 unless flush=1. flush has priority over req_valid: go to INIT; counters are kept.
//    req_valid&&req_ready registers write/set/tag, then go to LOOKUP.
//  - LOOKUP: all WAYS tags are compared in parallel against the registered tag, ANDed with valid.
//    Registers hit, way and victim, then goes to RESP. req_ready=0.
//  - Victim on miss: lowest-index invalid way; otherwise the way with age WAYS-1.
//  - Entering RESP, in the same edge: the line is installed on a miss (valid=1, tag written, dirty=req_write), or dirty|=req_write on a hit.
//    LRU update: accessed way age:=0, every way with age<old age increments; others unchanged.
//    Exactly one of hit_count/miss_count increments, saturating at 2^32-1.
//  - Eviction fields: evict_valid/dirty/tag carry the pre-replacement line state; all 0 on a hit.
//  - RESP: resp_valid=1 and all resp_* fields stable until resp_valid&&resp_ready, then IDLE. req_ready=0 in RESP.
//  - Latency: accept at edge N, resp_valid seen after edge N+2; throughput is at best 1 request per 3 cycles.
//  - Ages within a set are always a permutation of 0..WAYS-1.
//  - flush outside IDLE is ignored (no queuing).
// TESTING (WAYS=4, SET_W=3, OFFSET_W=3, TAG_W=18; set1 tag t => addr=(t<<6)|0x08)
//  1. Deassert rst: req_ready=0 for exactly 8 cycles, then 1.
//     Read 0x000008 -> resp_hit=0, way=0, evict_valid=0, miss_count=1; resp_valid 2 cycles after accept.
//  2. Read 0x000008 again -> hit=1, way=0, hit_count=1.
//     Read 0x000010 (set2) -> miss, way=0; no disturbance of set1.
//  3. Fill set1 with tags 0..3 (0x008,0x048,0x088,0x0C8), then write 0x008 (hit way0, dirty), then read 0x108 (tag4)
//     -> miss, way=1, evict_valid=1, evict_tag=1, evict_dirty=0.
//     Then tags 5,6,7 -> evict ways 2,3,0; the way0 eviction has evict_dirty=1, evict_tag=0.
//  4. Hold resp_ready=0 for 5 cycles: resp_valid and fields stable, req_ready=0, a pending req_valid is not accepted.
//     Release -> IDLE the next cycle.
//  5. flush=1 in IDLE with req_valid=1: no accept, req_ready=0 for 8 cycles.
//     Then read 0x000008 -> miss; counters unchanged by the flush.
//  6. Assert rst during LOOKUP: next cycle resp_valid=0, counters 0, INIT sweep restarts; no stale response is emitted.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative cache tag/replacement controller: tag, valid and dirty state per way,
// true-LRU ages per set, write-back eviction reporting, flush, and saturating hit/miss counters.
module set_assoc_cache_ctrl #(
    parameter int ADDR_W   = 24,
    parameter int OFFSET_W = 3,
    parameter int SET_W    = 3,
    parameter int WAYS     = 4,
    parameter int WAY_W    = 2,
    localparam int TAG_W   = ADDR_W - SET_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic              resp_evict_valid,
    output logic              resp_evict_dirty,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int SETS = 2 ** SET_W;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Per-set, per-way line state
    logic [TAG_W-1:0] r_tag_mem [SETS][WAYS];
    logic [WAYS-1:0]  r_valid   [SETS];
    logic [WAYS-1:0]  r_dirty   [SETS];
    logic [WAY_W-1:0] r_age     [SETS][WAYS];

    logic [SET_W-1:0] r_init_idx;
    logic             r_write;
    logic [SET_W-1:0] r_set;
    logic [TAG_W-1:0] r_tag;

    logic [WAYS-1:0]  w_hit_vec;
    logic [WAYS-1:0]  w_oldest_vec;
    logic [WAYS-1:0]  w_valid_row;
    logic [WAYS-1:0]  w_dirty_row;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_oldest_way;
    logic [WAY_W-1:0] w_victim_way;
    logic [WAY_W-1:0] w_way;
    logic [WAY_W-1:0] w_acc_age;
    logic             w_accept;
    logic             w_unused_offset;

    assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

    assign w_valid_row = r_valid[r_set];
    assign w_dirty_row = r_dirty[r_set];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_hit_vec[gi]    = w_valid_row[gi] && (r_tag_mem[r_set][gi] == r_tag);
            assign w_oldest_vec[gi] = (r_age[r_set][gi] == WAY_W'(WAYS - 1));
        end
    endgenerate

    // Lowest-index selection for hit, first invalid way and the LRU way
    always_comb begin
        w_hit_way    = '0;
        w_inv_way    = '0;
        w_oldest_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_hit_vec[i])      w_hit_way    = WAY_W'(i);
            if (!w_valid_row[i])   w_inv_way    = WAY_W'(i);
            if (w_oldest_vec[i])   w_oldest_way = WAY_W'(i);
        end
    end

    assign w_hit        = |w_hit_vec;
    assign w_victim_way = (&w_valid_row) ? w_oldest_way : w_inv_way;
    assign w_way        = w_hit ? w_hit_way : w_victim_way;
    assign w_acc_age    = r_age[r_set][w_way];
    assign w_accept     = (r_state == ST_IDLE) && !flush && req_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_idx == SET_W'(SETS - 1)) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = !flush;
                if (flush)          w_state_next = ST_INIT;
                else if (req_valid) w_state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Line arrays: swept by INIT, updated once per access on the LOOKUP->RESP edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_valid[r_init_idx] <= '0;
                r_dirty[r_init_idx] <= '0;
                for (int j = 0; j < WAYS; j++) r_age[r_init_idx][j] <= WAY_W'(j);
            end else if (r_state == ST_LOOKUP) begin
                if (w_hit) begin
                    r_dirty[r_set][w_way] <= w_dirty_row[w_way] | r_write;
                end else begin
                    r_valid[r_set][w_way]   <= 1'b1;
                    r_dirty[r_set][w_way]   <= r_write;
                    r_tag_mem[r_set][w_way] <= r_tag;
                end
                for (int j = 0; j < WAYS; j++) begin
                    if (WAY_W'(j) == w_way)
                        r_age[r_set][j] <= '0;
                    else if (r_age[r_set][j] < w_acc_age)
                        r_age[r_set][j] <= r_age[r_set][j] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_idx       <= '0;
            r_write          <= 1'b0;
            r_set            <= '0;
            r_tag            <= '0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_evict_valid <= 1'b0;
            resp_evict_dirty <= 1'b0;
            resp_evict_tag   <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            case (r_state)
                ST_INIT: r_init_idx <= r_init_idx + SET_W'(1);
                ST_IDLE: begin
                    r_init_idx <= '0;
                    if (w_accept) begin
                        r_write <= req_write;
                        r_set   <= req_addr[OFFSET_W +: SET_W];
                        r_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                    end
                end
                ST_LOOKUP: begin
                    resp_hit <= w_hit;
                    resp_way <= w_way;
                    if (w_hit) begin
                        resp_evict_valid <= 1'b0;
                        resp_evict_dirty <= 1'b0;
                        resp_evict_tag   <= '0;
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
                    end else begin
                        resp_evict_valid <= w_valid_row[w_way];
                        resp_evict_dirty <= w_valid_row[w_way] & w_dirty_row[w_way];
                        resp_evict_tag   <= w_valid_row[w_way] ? r_tag_mem[r_set][w_way] : '0;
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: reset sweep, hit/miss, LRU eviction,
// response backpressure, flush and reset during a lookup.
module tb_set_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        resp_evict_valid;
    logic        resp_evict_dirty;
    logic [17:0] resp_evict_tag;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_chk = 0;
    int n_err = 0;

    logic        t_hit;
    logic [1:0]  t_way;
    logic        t_ev;
    logic        t_ed;
    logic [17:0] t_etag;
    int          t_lat;

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_evict_valid(resp_evict_valid), .resp_evict_dirty(resp_evict_dirty),
        .resp_evict_tag(resp_evict_tag), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, waits for its response, captures it and consumes it.
    task automatic transact(input logic w, input logic [23:0] a);
        int k;
        req_write = w; req_addr = a; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 40) begin tick(); k++; end
        if (!req_ready) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout addr=%h req_ready=%0b required 1", a, req_ready);
            req_valid = 1'b0; t_lat = -1;
            return;
        end
        t_lat = 0;
        tick();
        req_valid = 1'b0;
        t_lat = 1;
        while (!resp_valid && t_lat < 40) begin tick(); t_lat++; end
        if (!resp_valid) begin
            n_chk++; n_err++;
            $display("FAIL resp_timeout addr=%h resp_valid=%0b required 1", a, resp_valid);
            t_lat = -1;
            return;
        end
        t_hit = resp_hit; t_way = resp_way; t_ev = resp_evict_valid;
        t_ed = resp_evict_dirty; t_etag = resp_evict_tag;
        $display("txn %s addr=%h hit=%0b way=%0d ev=%0b ed=%0b etag=%0h lat=%0d hits=%0d misses=%0d",
                 w ? "WR" : "RD", a, t_hit, t_way, t_ev, t_ed, t_etag, t_lat, hit_count, miss_count);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Counts cycles with req_ready low after the current point (bounded).
    task automatic count_init(output int cnt, output logic saw_resp);
        cnt = 0; saw_resp = 1'b0;
        while (!req_ready && cnt < 50) begin
            if (resp_valid) saw_resp = 1'b1;
            cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        int cnt; logic sr;
        rst = 1'b1;
        tick(); tick();
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
        n_chk++; if ({hit_count, miss_count} !== 64'd0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        n_chk++; if ({resp_hit, resp_way, resp_evict_valid, resp_evict_dirty, resp_evict_tag} !== '0) begin n_err++; $display("FAIL reset_resp_fields not zero"); end
        rst = 1'b0;
        count_init(cnt, sr);
        n_chk++; if (cnt !== 8) begin n_err++; $display("FAIL reset_init_cycles got=%0d exp=8", cnt); end
    endtask

    task automatic test_basic();
        transact(1'b0, 24'h000008);
        n_chk++; if ({t_hit, t_way, t_ev} !== 4'b0_00_0) begin n_err++; $display("FAIL first_miss got hit=%0b way=%0d ev=%0b exp 0/0/0", t_hit, t_way, t_ev); end
        n_chk++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL first_miss_count got=%0d exp=1", miss_count); end
        n_chk++; if (t_lat !== 2) begin n_err++; $display("FAIL latency got=%0d exp=2", t_lat); end
        transact(1'b0, 24'h000008);
        n_chk++; if ({t_hit, t_way} !== 3'b1_00) begin n_err++; $display("FAIL repeat_hit got hit=%0b way=%0d exp 1/0", t_hit, t_way); end
        n_chk++; if (hit_count !== 32'd1) begin n_err++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
        transact(1'b0, 24'h000010);
        n_chk++; if ({t_hit, t_way, t_ev} !== 4'b0_00_0) begin n_err++; $display("FAIL set2_miss got hit=%0b way=%0d ev=%0b exp 0/0/0", t_hit, t_way, t_ev); end
        transact(1'b0, 24'h000008);
        n_chk++; if ({t_hit, t_way} !== 3'b1_00) begin n_err++; $display("FAIL set1_undisturbed got hit=%0b way=%0d exp 1/0", t_hit, t_way); end
        n_chk++; if ({hit_count, miss_count} !== {32'd2, 32'd2}) begin n_err++; $display("FAIL counts_basic got=%0d/%0d exp=2/2", hit_count, miss_count); end
    endtask

    task automatic test_evict();
        logic [23:0] fill_a [3] = '{24'h000048, 24'h000088, 24'h0000C8};
        logic [23:0] ev_a   [4] = '{24'h000108, 24'h000148, 24'h000188, 24'h0001C8};
        logic [1:0]  ev_way [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [17:0] ev_tag [4] = '{18'd1, 18'd2, 18'd3, 18'd0};
        logic        ev_drt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            transact(1'b0, fill_a[i]);
            n_chk++; if ({t_hit, t_way, t_ev} !== {1'b0, 2'(i + 1), 1'b0}) begin n_err++; $display("FAIL fill%0d got hit=%0b way=%0d ev=%0b exp 0/%0d/0", i, t_hit, t_way, t_ev, i + 1); end
        end
        transact(1'b1, 24'h000008);
        n_chk++; if ({t_hit, t_way, t_ev} !== 4'b1_00_0) begin n_err++; $display("FAIL write_hit got hit=%0b way=%0d ev=%0b exp 1/0/0", t_hit, t_way, t_ev); end
        for (int i = 0; i < 4; i++) begin
            transact(1'b0, ev_a[i]);
            n_chk++; if ({t_hit, t_way, t_ev, t_ed, t_etag} !== {1'b0, ev_way[i], 1'b1, ev_drt[i], ev_tag[i]}) begin
                n_err++; $display("FAIL evict%0d got hit=%0b way=%0d ev=%0b ed=%0b etag=%0h exp 0/%0d/1/%0b/%0h",
                                  i, t_hit, t_way, t_ev, t_ed, t_etag, ev_way[i], ev_drt[i], ev_tag[i]);
            end
        end
        n_chk++; if ({hit_count, miss_count} !== {32'd3, 32'd9}) begin n_err++; $display("FAIL counts_evict got=%0d/%0d exp=3/9", hit_count, miss_count); end
    endtask

    task automatic test_backpressure();
        int k;
        req_write = 1'b0; req_addr = 24'h0001C8; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 40) begin tick(); k++; end
        tick();
        k = 0;
        while (!resp_valid && k < 40) begin tick(); k++; end
        for (int c = 0; c < 5; c++) begin
            n_chk++; if ({resp_valid, resp_hit, resp_way, resp_evict_valid, req_ready} !== 6'b1_1_00_0_0) begin
                n_err++; $display("FAIL hold_cycle%0d got v=%0b hit=%0b way=%0d ev=%0b rdy=%0b exp 1/1/0/0/0",
                                  c, resp_valid, resp_hit, resp_way, resp_evict_valid, req_ready);
            end
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_chk++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL release_idle got v=%0b rdy=%0b exp 0/1", resp_valid, req_ready); end
        n_chk++; if ({hit_count, miss_count} !== {32'd4, 32'd9}) begin n_err++; $display("FAIL counts_hold got=%0d/%0d exp=4/9", hit_count, miss_count); end
    endtask

    task automatic test_flush();
        int cnt; logic sr;
        req_write = 1'b0; req_addr = 24'h000008; req_valid = 1'b1; flush = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%0b exp=0", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        count_init(cnt, sr);
        n_chk++; if (cnt !== 8) begin n_err++; $display("FAIL flush_init_cycles got=%0d exp=8", cnt); end
        n_chk++; if ({hit_count, miss_count} !== {32'd4, 32'd9}) begin n_err++; $display("FAIL flush_counts got=%0d/%0d exp=4/9", hit_count, miss_count); end
        transact(1'b0, 24'h000008);
        n_chk++; if ({t_hit, t_way, t_ev} !== 4'b0_00_0) begin n_err++; $display("FAIL after_flush got hit=%0b way=%0d ev=%0b exp 0/0/0", t_hit, t_way, t_ev); end
        n_chk++; if (miss_count !== 32'd10) begin n_err++; $display("FAIL after_flush_miss got=%0d exp=10", miss_count); end
    endtask

    task automatic test_reset_lookup();
        int cnt; logic sr;
        int k;
        req_write = 1'b0; req_addr = 24'h000008; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 40) begin tick(); k++; end
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_chk++; if ({resp_valid, req_ready} !== 2'b00) begin n_err++; $display("FAIL rst_lookup_handshake got v=%0b rdy=%0b exp 0/0", resp_valid, req_ready); end
        n_chk++; if ({hit_count, miss_count} !== 64'd0) begin n_err++; $display("FAIL rst_lookup_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        rst = 1'b0;
        count_init(cnt, sr);
        n_chk++; if (cnt !== 8) begin n_err++; $display("FAIL rst_lookup_init got=%0d exp=8", cnt); end
        n_chk++; if (sr !== 1'b0) begin n_err++; $display("FAIL stale_resp got=%0b exp=0", sr); end
        n_chk++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_resp_valid got=%0b exp=0", resp_valid); end
        transact(1'b0, 24'h000008);
        n_chk++; if ({t_hit, hit_count, miss_count} !== {1'b0, 32'd0, 32'd1}) begin n_err++; $display("FAIL post_rst got hit=%0b counts=%0d/%0d exp 0 0/1", t_hit, hit_count, miss_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_evict();
        test_backpressure();
        test_flush();
        test_reset_lookup();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
